// File: rtl/btram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : btram_arbiter_if
// Purpose  : PicoRV32 native memory handshake for one requester port
//            (valid/ready pulse, byte address, write data, byte strobes,
//            read data).
// Revision : 1.0  initial release
// ============================================================================
interface btram_arbiter_if #(
   parameter int DATA_WIDTH = 32
);
   logic                    valid;
   logic                    ready;
   logic [31:0]             addr;
   logic [DATA_WIDTH-1:0]   wdata;
   logic [3:0]              wstrb;
   logic [DATA_WIDTH-1:0]   rdata;

   // Requester side
   modport master (
      output valid, addr, wdata, wstrb,
      input  ready, rdata
   );

   // Arbiter side
   modport slave (
      input  valid, addr, wdata, wstrb,
      output ready, rdata
   );
endinterface
`default_nettype wire

// File: rtl/btram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : btram_arbiter
// Purpose  : Shares one single-port byte-enabled synchronous RAM (1-cycle
//            registered read) between two PicoRV32-style requesters.
//            Port 0 = CPU bus, port 1 = secondary master (loader / DMA).
//            Each access runs IDLE -> ISSUE -> RESP -> IDLE.
// Options  : BTRAM_ARB_RR_EN  defined   -> round-robin arbitration
//                             undefined -> fixed priority, port 0 wins
// Revision : 1.0  initial release
// ============================================================================
module btram_arbiter #(
   parameter  int DATA_WIDTH = 32,
   parameter  int DATA_DEPTH = 512,
   localparam int AW         = $clog2(DATA_DEPTH)
) (
   input  wire logic                  clock,
   input  wire logic                  resetn,
   btram_arbiter_if.slave             m0,
   btram_arbiter_if.slave             m1,
   output logic [AW-1:0]              ram_address,
   output logic [3:0]                 ram_byteena,
   output logic [DATA_WIDTH-1:0]      ram_data,
   output logic                       ram_wren,
   input  wire logic [DATA_WIDTH-1:0] ram_q,
   output logic                       grant,
   output logic                       busy
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_RESP  = 2'd2;

   logic [1:0]            r_state;
   logic [1:0]            w_next_state;
   logic                  r_grant;
   logic [AW-1:0]         r_ram_address;
   logic [3:0]            r_ram_byteena;
   logic [DATA_WIDTH-1:0] r_ram_data;
   logic                  r_ram_wren;

   logic                  w_any_valid;
   logic                  w_winner;
   logic                  w_accept;
   logic [31:0]           w_sel_addr;
   logic [DATA_WIDTH-1:0] w_sel_wdata;
   logic [3:0]            w_sel_wstrb;
   logic                  w_unused_addr_bits;

   assign w_any_valid = m0.valid | m1.valid;
   assign w_accept    = (r_state == S_IDLE) && w_any_valid;

`ifdef BTRAM_ARB_RR_EN
   logic r_last_grant;

   // Round-robin: on contention the port that did not win last time wins
   always_comb begin
      w_winner = 1'b0;
      if (m0.valid && m1.valid) begin
         w_winner = ~r_last_grant;
      end else if (m1.valid) begin
         w_winner = 1'b1;
      end
   end

   // Remember the most recent winner for the next contention
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_last_grant <= 1'b0;
      end else if (w_accept) begin
         r_last_grant <= w_winner;
      end
   end
`else
   // Fixed priority: port 1 only wins when port 0 is not requesting
   assign w_winner = ~m0.valid;
`endif

   assign w_sel_addr  = w_winner ? m1.addr  : m0.addr;
   assign w_sel_wdata = w_winner ? m1.wdata : m0.wdata;
   assign w_sel_wstrb = w_winner ? m1.wstrb : m0.wstrb;

   // Byte offset and bits above the RAM size are dropped, so addresses alias
   assign w_unused_addr_bits = ^{w_sel_addr[31:AW+2], w_sel_addr[1:0]};

   // State register
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic: only IDLE waits, the rest of the sequence is fixed
   always_comb begin
      w_next_state = S_IDLE;
      case (r_state)
         S_IDLE:  w_next_state = w_any_valid ? S_ISSUE : S_IDLE;
         S_ISSUE: w_next_state = S_RESP;
         S_RESP:  w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   // RAM request registers: loaded on accept, write strobe cleared after ISSUE
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_grant       <= 1'b0;
         r_ram_address <= '0;
         r_ram_byteena <= '0;
         r_ram_data    <= '0;
         r_ram_wren    <= 1'b0;
      end else if (w_accept) begin
         r_grant       <= w_winner;
         r_ram_address <= w_sel_addr[AW+1:2];
         r_ram_byteena <= w_sel_wstrb;
         r_ram_data    <= w_sel_wdata;
         r_ram_wren    <= (w_sel_wstrb != 4'd0);
      end else if (r_state == S_ISSUE) begin
         r_ram_wren    <= 1'b0;
      end
   end

   // Outputs: completion pulse and read data routed to the granted port only
   always_comb begin
      m0.ready = 1'b0;
      m1.ready = 1'b0;
      m0.rdata = '0;
      m1.rdata = '0;
      busy     = (r_state != S_IDLE);
      if (r_state == S_RESP) begin
         if (r_grant) begin
            m1.ready = 1'b1;
            m1.rdata = ram_q;
         end else begin
            m0.ready = 1'b1;
            m0.rdata = ram_q;
         end
      end
   end

   assign grant       = r_grant;
   assign ram_address = r_ram_address;
   assign ram_byteena = r_ram_byteena;
   assign ram_data    = r_ram_data;
   assign ram_wren    = r_ram_wren;

endmodule
`default_nettype wire

// File: tb/tb_btram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_btram_arbiter
// Purpose  : Self-checking bench for btram_arbiter with a behavioural RAM,
//            a reference memory and a response scoreboard.
// Revision : 1.0  initial release
// ============================================================================
module tb_btram_arbiter;
   localparam int DEPTH = 512;

   logic        clock  = 1'b0;
   logic        resetn = 1'b0;
   logic [8:0]  ram_address;
   logic [3:0]  ram_byteena;
   logic [31:0] ram_data;
   logic        ram_wren;
   logic [31:0] ram_q = 32'd0;
   logic        grant;
   logic        busy;

   btram_arbiter_if m0 ();
   btram_arbiter_if m1 ();

   btram_arbiter #(.DATA_WIDTH(32), .DATA_DEPTH(DEPTH)) dut (
      .clock       (clock),
      .resetn      (resetn),
      .m0          (m0),
      .m1          (m1),
      .ram_address (ram_address),
      .ram_byteena (ram_byteena),
      .ram_data    (ram_data),
      .ram_wren    (ram_wren),
      .ram_q       (ram_q),
      .grant       (grant),
      .busy        (busy)
   );

   always #5 clock = ~clock;

   // Behavioural single-port RAM: byte-lane writes, registered read-before-write
   logic [31:0] ram_mem [DEPTH];
   always @(posedge clock) begin
      if (ram_wren) begin
         for (int b = 0; b < 4; b++) begin
            if (ram_byteena[b]) ram_mem[ram_address][8*b +: 8] <= ram_data[8*b +: 8];
         end
      end
      ram_q <= ram_mem[ram_address];
   end

   logic [31:0] ref_mem [DEPTH];
   logic [32:0] exp_q [$];
   int total = 0;
   int bad   = 0;
   int wren_seen = 0;
   int ready_cnt = 0;
   int served1   = 0;
   logic [32:0] mon_e;
   logic        mon_port;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
      end
   endtask

   // Response monitor: every ready pulse must match the next scoreboard entry
   always @(negedge clock) begin
      if (ram_wren) wren_seen++;
      if (m0.ready || m1.ready) begin
         check("ready_onehot", 32'(m0.ready & m1.ready), 32'd0);
         mon_port = m1.ready;
         if (exp_q.size() == 0) begin
            check("unexpected_ready", 32'd1, 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check("resp_port",  32'(mon_port), 32'(mon_e[32]));
            check("resp_grant", 32'(grant),    32'(mon_e[32]));
            check("rdata", mon_port ? m1.rdata : m0.rdata, mon_e[31:0]);
            check("other_rdata", mon_port ? m0.rdata : m1.rdata, 32'd0);
         end
         ready_cnt++;
         if (mon_port) served1++;
      end
   end

   task automatic drive(input bit p, input logic v, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] ws);
      if (!p) begin
         m0.valid = v; m0.addr = a; m0.wdata = wd; m0.wstrb = ws;
      end else begin
         m1.valid = v; m1.addr = a; m1.wdata = wd; m1.wstrb = ws;
      end
   endtask

   // Reference model: response carries the pre-write word, then merge the write
   task automatic expect_access(input bit p, input logic [31:0] a,
                                input logic [31:0] wd, input logic [3:0] ws);
      int idx;
      idx = int'((a >> 2) % DEPTH);
      exp_q.push_back({p, ref_mem[idx]});
      for (int b = 0; b < 4; b++) begin
         if (ws[b]) ref_mem[idx][8*b +: 8] = wd[8*b +: 8];
      end
   endtask

   task automatic wait_ready(input bit p, input logic [31:0] a, input logic [3:0] ws,
                             input int w0);
      int n;
      bit got;
      n = 0;
      got = 1'b0;
      while (!got && n < 10) begin
         @(negedge clock);
         n++;
         if (n == 2) begin
            check("issue_addr", 32'(ram_address), (a >> 2) % DEPTH);
            check("issue_be",   32'(ram_byteena), 32'(ws));
            check("issue_busy", 32'(busy), 32'd1);
         end
         if (p ? m1.ready : m0.ready) got = 1'b1;
      end
      check("latency", 32'(n), 32'd3);
      @(posedge clock);
      #1;
      drive(p, 1'b0, 32'd0, 32'd0, 4'd0);
      check("wren_cycles", 32'(wren_seen - w0), 32'(ws != 4'd0));
   endtask

   task automatic do_access(input bit p, input logic [31:0] a,
                            input logic [31:0] wd, input logic [3:0] ws);
      int w0;
      @(posedge clock);
      #1;
      expect_access(p, a, wd, ws);
      w0 = wren_seen;
      drive(p, 1'b1, a, wd, ws);
      wait_ready(p, a, ws, w0);
   endtask

   initial begin
      bit seq [5];
      int n;
      int w0;
      int served1_at4;
`ifdef BTRAM_ARB_RR_EN
      seq = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`else
      seq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`endif
      for (int i = 0; i < DEPTH; i++) begin
         ram_mem[i] = 32'd0;
         ref_mem[i] = 32'd0;
      end
      drive(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
      drive(1'b1, 1'b0, 32'd0, 32'd0, 4'd0);

      // Reset state
      repeat (2) @(posedge clock);
      #1;
      check("rst_wren",  32'(ram_wren), 32'd0);
      check("rst_addr",  32'(ram_address), 32'd0);
      check("rst_be",    32'(ram_byteena), 32'd0);
      check("rst_data",  ram_data, 32'd0);
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_busy",  32'(busy), 32'd0);
      check("rst_ready", 32'({m0.ready, m1.ready}), 32'd0);
      check("rst_rdata", m0.rdata | m1.rdata, 32'd0);
      resetn = 1'b1;

      // Single-port traffic: full write, read back, byte merge, aliasing
      do_access(1'b0, 32'h10,  32'hDEADBEEF, 4'hF);
      do_access(1'b0, 32'h10,  32'h0,        4'h0);
      do_access(1'b1, 32'h10,  32'h0000AA00, 4'h2);
      do_access(1'b1, 32'h10,  32'h0,        4'h0);
      do_access(1'b0, 32'h0,   32'hCAFEF00D, 4'hF);
      do_access(1'b1, 32'h800, 32'h0,        4'h0);
      do_access(1'b1, 32'h7FC, 32'h11223344, 4'h9);
      do_access(1'b0, 32'h7FC, 32'h0,        4'h0);

      // Reset asserted during ISSUE of a write
      @(posedge clock);
      #1;
      drive(1'b0, 1'b1, 32'h20, 32'h12345678, 4'hF);
      @(posedge clock);
      #2;
      check("mid_wren_pre", 32'(ram_wren), 32'd1);
      resetn = 1'b0;
      #1;
      check("mid_rst_wren", 32'(ram_wren), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      @(posedge clock);
      #1;
      check("abort_mem", ram_mem[8], 32'd0);
      expect_access(1'b0, 32'h20, 32'h12345678, 4'hF);
      w0 = wren_seen;
      resetn = 1'b1;
      wait_ready(1'b0, 32'h20, 4'hF, w0);
      do_access(1'b0, 32'h20, 32'h0, 4'h0);

      // Contention from a fresh reset so the round-robin pointer starts at 0
      @(posedge clock);
      #1;
      resetn = 1'b0;
      @(posedge clock);
      #1;
      resetn = 1'b1;
      for (int i = 0; i < 5; i++) expect_access(seq[i], seq[i] ? 32'h0 : 32'h10, 32'd0, 4'd0);
      ready_cnt = 0;
      served1   = 0;
      drive(1'b0, 1'b1, 32'h10, 32'd0, 4'd0);
      drive(1'b1, 1'b1, 32'h0,  32'd0, 4'd0);
      n = 0;
      while (ready_cnt < 4 && n < 40) begin
         @(posedge clock);
         n++;
      end
      check("contend4_timeout", 32'(n < 40), 32'd1);
      served1_at4 = served1;
      #1;
      drive(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
`ifdef BTRAM_ARB_RR_EN
      check("m1_served_of4", 32'(served1_at4), 32'd2);
`else
      check("m1_served_of4", 32'(served1_at4), 32'd0);
`endif
      n = 0;
      while (ready_cnt < 5 && n < 20) begin
         @(posedge clock);
         n++;
      end
      check("contend5_timeout", 32'(n < 20), 32'd1);
      #1;
      drive(1'b1, 1'b0, 32'd0, 32'd0, 4'd0);

      repeat (4) @(posedge clock);
      #1;
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      check("final_busy", 32'(busy), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/btram_arbiter.md
Name: btram_arbiter

Overview:
- Shares one single-port, byte-enabled synchronous RAM (1-cycle registered read, byte-lane writes) between two requesters using the PicoRV32 native memory handshake.
- Port 0 is the CPU data/instruction bus; port 1 is a secondary master (UART loader / DMA).
- Sequences each access as issue, RAM cycle, response, and returns read data to the granted port.

Parameters:
- DATA_WIDTH, 32, word width of requesters and RAM; must be 32.
- DATA_DEPTH, 512, RAM depth in words; power of two.
- AW, $clog2(DATA_DEPTH), RAM word-address width (derived; not overridden).

Ports:
- clock  in  1  system clock; all state on rising edge
- resetn  in  1  asynchronous active-low reset
- m0_valid  in  1  port 0 request
- m0_ready  out  1  port 0 completion pulse
- m0_addr  in  32  port 0 byte address
- m0_wdata  in  32  port 0 write data
- m0_wstrb  in  4  port 0 byte strobes; 0 = read
- m0_rdata  out  32  port 0 read data
- m1_valid, m1_ready, m1_addr, m1_wdata, m1_wstrb, m1_rdata  same as port 0, for port 1
- ram_address  out  AW  RAM word address
- ram_byteena  out  4  RAM byte enables
- ram_data  out  32  RAM write data
- ram_wren  out  1  RAM write enable
- ram_q  in  32  RAM registered read data
- grant  out  1  index of the port owning the current access
- busy  out  1  high when state is not IDLE

Behaviour:
- Reset (async, resetn=0): state=IDLE, ram_wren=0, ram_address=0, ram_byteena=0, ram_data=0, grant=0, last_grant=0, m0_ready=m1_ready=0, m0_rdata=m1_rdata=0, busy=0.
- FSM: IDLE -> ISSUE -> RESP -> IDLE. Every transition is unconditional except IDLE.
- IDLE: if neither valid is high, stay in IDLE. Otherwise select a winner per the arbitration rule, then on the clock edge:
  - grant <= winner
  - ram_address <= addr[AW+1:2]; upper address bits are ignored, so addresses alias modulo RAM size
  - ram_data <= wdata
  - ram_byteena <= wstrb
  - ram_wren <= (wstrb != 0)
  - go to ISSUE
- ISSUE: the RAM samples its inputs on the edge ending this cycle; the write is committed and ram_q loads the old word. On that edge ram_wren <= 0, then go to RESP. ram_address, ram_byteena and ram_data hold their values.
- RESP: combinationally drive m<grant>_ready=1 and m<grant>_rdata=ram_q. The other port has ready=0 and rdata=0. Go to IDLE.
- Writes: rdata in RESP is the pre-write word; requesters ignore it.
- Latency: valid sampled in IDLE at cycle t gives ready high during cycle t+2. Maximum throughput is one access per 3 cycles.
- Requester rules:
  - hold valid, addr, wdata and wstrb stable from assertion until ready is sampled
  - deassert valid on the edge that samples ready; IDLE at t+3 therefore does not re-accept the completed request
- The losing port's request stays pending; it is granted no earlier than the next IDLE.
- ram_wren is high for exactly one cycle per write access and never during reads or IDLE.
- Reset mid-access: all state clears immediately and ram_wren drops asynchronously. A write in ISSUE is aborted unless the clock edge has already occurred. No ready is issued. A still-asserted valid is served after reset release.
- A valid that drops without ready being seen is a protocol violation. Behaviour is defined only as: the access completes, and ready is pulsed anyway.

Optional Feature:
- Macro BTRAM_ARB_RR_EN.
- Defined: round-robin arbitration. When both valids are high in IDLE, winner = ~last_grant. With a single request, that port wins. last_grant <= winner on every grant.
- Undefined: fixed priority, port 0 always wins. last_grant is not implemented. Port 1 can starve under continuous port 0 traffic.

Test Plan:
- Reset, then m0 write addr=0x10, wdata=0xDEADBEEF, wstrb=0xF -> ram_wren high one cycle with ram_address=4, ram_byteena=0xF; m0_ready pulses at t+2; m1_ready stays 0.
- m0 read addr=0x10 after that write -> m0_ready at t+2 with m0_rdata=0xDEADBEEF; ram_wren stays 0.
- m1 write wstrb=0x2, wdata=0x0000AA00 to addr 0x10, then m1 read -> m1_rdata=0xDEADAAEF.
- m0 and m1 both valid continuously for 4 accesses:
  - with BTRAM_ARB_RR_EN: grant sequence 1,0,1,0 (last_grant=0 after reset)
  - without: 0,0,0,0 and m1 never served
- Address alias: m1 read addr=0x800 with DATA_DEPTH=512 -> ram_address=0; data equals word at addr 0x0.
- Assert resetn=0 during ISSUE of a write -> ram_wren=0 immediately; no ready pulse. After release with valid still high, the access completes in 3 cycles.
